boot_sequencer: RTL and testbench

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

---
 rtl/boot_sequencer.sv | 127 ++++++++++++
 tb/tb_boot_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_sequencer.sv
// Boot sequencer: after reset, waits for the BIOS ROM to settle, copies
// BOOT_WORDS words from the BIOS into instruction memory one per cycle while
// holding the CPU, accumulates a 32-bit checksum, then releases the CPU.
// A start pulse while released re-runs the copy without the settle wait.
module boot_sequencer #(
  parameter int BOOT_WORDS  = 186,
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] bios_address,
  input  logic [31:0]       bios_instruction,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_wr_addr,
  output logic [31:0]       imem_wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic [31:0]       checksum
);

  localparam int WAIT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BOOT_WORDS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_COPY,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] cnt, cnt_d;
  logic [WAIT_W-1:0] wait_cnt, wait_d;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [31:0]       wr_data_d;
  logic [31:0]       sum_d;
  logic              hold_d;
  logic              done_d;

  // The BIOS read address is the word counter register itself.
  assign bios_address = cnt;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_WAIT;
    else        state <= state_d;
  end

  // Next-state and next-register values; everything holds unless a state acts.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    wait_d    = wait_cnt;
    wr_en_d   = 1'b0;
    wr_addr_d = imem_wr_addr;
    wr_data_d = imem_wr_data;
    sum_d     = checksum;
    hold_d    = cpu_hold;
    done_d    = done;
    unique case (state)
      ST_WAIT: begin
        // Give the BIOS its first-clock initialisation before reading it.
        if (wait_cnt == WAIT_LAST) begin
          state_d = ST_COPY;
          cnt_d   = '0;
          wait_d  = '0;
        end else begin
          wait_d  = wait_cnt + WAIT_W'(1);
        end
      end
      ST_COPY: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt;
        wr_data_d = bios_instruction;
        sum_d     = checksum + bios_instruction;
        // Counter saturates on the last word so the BIOS address never
        // runs past the image.
        if (cnt < LAST_ADDR) cnt_d   = cnt + ADDR_W'(1);
        else                 state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // Last write is on the bus this cycle; release the CPU behind it.
        hold_d  = 1'b0;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_COPY;
          cnt_d   = '0;
          sum_d   = '0;
          done_d  = 1'b0;
          hold_d  = 1'b1;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      wait_cnt     <= '0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= '0;
      imem_wr_data <= '0;
      checksum     <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
    end else begin
      cnt          <= cnt_d;
      wait_cnt     <= wait_d;
      imem_wr_en   <= wr_en_d;
      imem_wr_addr <= wr_addr_d;
      imem_wr_data <= wr_data_d;
      checksum     <= sum_d;
      cpu_hold     <= hold_d;
      done         <= done_d;
    end
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// Scoreboarded bench for boot_sequencer: default-parameter instance A with a
// random BIOS image, plus a single-word instance B.
module tb_boot_sequencer;

  localparam int N  = 186;
  localparam int AW = 12;
  localparam int WC = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // ---------------- instance A (defaults) ----------------
  logic          rst_a, start_a;
  logic [AW-1:0] ba_a, wa_a;
  logic [31:0]   bi_a, wd_a, sum_a;
  logic          we_a, hold_a, done_a;
  logic [31:0]   rom_a [N];

  assign bi_a = (int'(ba_a) < N) ? rom_a[int'(ba_a)] : 32'hBAD0BAD0;

  boot_sequencer dut_a (
    .clock(clock), .reset(rst_a), .start(start_a),
    .bios_address(ba_a), .bios_instruction(bi_a),
    .imem_wr_en(we_a), .imem_wr_addr(wa_a), .imem_wr_data(wd_a),
    .cpu_hold(hold_a), .done(done_a), .checksum(sum_a)
  );

  // ---------------- instance B (single word) ----------------
  logic          rst_b, start_b;
  logic [AW-1:0] ba_b, wa_b;
  logic [31:0]   bi_b, wd_b, sum_b;
  logic          we_b, hold_b, done_b;

  assign bi_b = (ba_b == '0) ? 32'hFFFFFFFF : 32'h0BAD0BAD;

  boot_sequencer #(.BOOT_WORDS(1), .ADDR_W(AW), .WAIT_CYCLES(WC)) dut_b (
    .clock(clock), .reset(rst_b), .start(start_b),
    .bios_address(ba_b), .bios_instruction(bi_b),
    .imem_wr_en(we_b), .imem_wr_addr(wa_b), .imem_wr_data(wd_b),
    .cpu_hold(hold_b), .done(done_b), .checksum(sum_b)
  );

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] sum_q[$];
  logic [31:0] exp_sum_last;
  int          exp_boots = 0;
  int          boots_a   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fill_rom();
    for (int k = 0; k < N; k++) rom_a[k] = $urandom;
    rom_a[0]   = 32'h2000007A;
    rom_a[N-1] = 32'h2C000000;
  endtask

  // One boot = every image word written in address order; checksum is their sum.
  task automatic push_boot();
    wr_t         e;
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < N; k++) begin
      e.addr = AW'(k);
      e.data = rom_a[k];
      exp_q.push_back(e);
      s = s + rom_a[k];
    end
    sum_q.push_back(s);
    exp_sum_last = s;
    exp_boots++;
  endtask

  // Monitor for A: pops expected writes, checks run length and completion.
  int            run_a = 0;
  logic          pw_en = 1'b0;
  logic          pdone = 1'b0;
  logic [AW-1:0] paddr = '0;

  always @(negedge clock) begin
    if (!rst_a) begin
      run_a = 0;
      pw_en = 1'b0;
      pdone = 1'b0;
      paddr = '0;
    end else begin
      check("done_vs_hold", 32'(done_a), 32'(!hold_a));
      check("addr_bound", 32'(ba_a <= AW'(N-1)), 32'd1);
      if (we_a) begin
        run_a++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr %0d expected no write", wa_a);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(wa_a), 32'(e.addr));
          check("wr_data", wd_a, e.data);
        end
      end else if (pw_en) begin
        check("wr_run_len", 32'(run_a), 32'(N));
        run_a = 0;
      end
      if (done_a && !pdone) begin
        boots_a++;
        check("done_prev_wr_en", 32'(pw_en), 32'd1);
        check("done_prev_addr", 32'(paddr), 32'(N-1));
        check("done_wr_en_low", 32'(we_a), 32'd0);
        if (sum_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got checksum %h expected no boot", sum_a);
        end else begin
          check("checksum", sum_a, sum_q.pop_front());
        end
      end
      pw_en = we_a;
      paddr = wa_a;
      pdone = done_a;
    end
  end

  // Monitor for B: counts write cycles of the current boot.
  int            b_cnt = 0;
  logic [AW-1:0] b_addr;
  logic [31:0]   b_data;

  always @(negedge clock) begin
    if (rst_b && we_b) begin
      b_cnt++;
      b_addr = wa_b;
      b_data = wd_b;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_done_a(input int max);
    int i;
    i = 0;
    while (!done_a && i < max) begin
      @(posedge clock); #1;
      i++;
    end
    check("done_a_reached", 32'(done_a), 32'd1);
  endtask

  task automatic wait_done_b(input int max);
    int i;
    i = 0;
    while (!done_b && i < max) begin
      @(posedge clock); #1;
      i++;
    end
    check("done_b_reached", 32'(done_b), 32'd1);
  endtask

  // Release reset between edges with start held high (must be ignored) and
  // check the first write lands on edge WC+1.
  task automatic release_and_boot();
    fill_rom();
    push_boot();
    start_a = 1'b1;
    rst_a   = 1'b1;
    for (int e = 1; e <= WC + 1; e++) begin
      @(posedge clock); #1;
      if (e <= WC) begin
        check("wait_no_wr", 32'(we_a), 32'd0);
        check("wait_hold", 32'(hold_a), 32'd1);
      end else begin
        check("first_wr_edge", 32'(we_a), 32'd1);
        check("first_wr_addr", 32'(wa_a), 32'd0);
        check("first_wr_data", wd_a, 32'h2000007A);
      end
    end
    start_a = 1'b0;
  endtask

  task automatic check_b_boot();
    check("b_write_count", 32'(b_cnt), 32'd1);
    check("b_write_addr", 32'(b_addr), 32'd0);
    check("b_write_data", b_data, 32'hFFFFFFFF);
    check("b_checksum", sum_b, 32'hFFFFFFFF);
    check("b_bios_addr", 32'(ba_b), 32'd0);
    check("b_hold", 32'(hold_b), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int idle;
    int i;
    rst_a = 1'b0; rst_b = 1'b0;
    start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_bios_addr", 32'(ba_a), 32'd0);
    check("rst_wr_en", 32'(we_a), 32'd0);
    check("rst_wr_addr", 32'(wa_a), 32'd0);
    check("rst_wr_data", wd_a, 32'd0);
    check("rst_checksum", sum_a, 32'd0);
    check("rst_hold", 32'(hold_a), 32'd1);
    check("rst_done", 32'(done_a), 32'd0);

    // First boot from reset.
    release_and_boot();
    wait_done_a(400);

    // Checksum and done hold while idle in DONE.
    idle = $urandom_range(1, 6);
    repeat (idle) begin
      @(posedge clock); #1;
      check("idle_checksum", sum_a, exp_sum_last);
      check("idle_done", 32'(done_a), 32'd1);
    end

    // Start pulse: immediate re-copy, no settle wait, same image.
    push_boot();
    start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    check("restart_hold", 32'(hold_a), 32'd1);
    check("restart_done", 32'(done_a), 32'd0);
    check("restart_checksum_clr", sum_a, 32'd0);
    @(posedge clock); #1;
    check("restart_no_wait", 32'(we_a), 32'd1);
    check("restart_addr0", 32'(wa_a), 32'd0);
    wait_done_a(400);

    // New image, start held high through COPY/DRAIN: exactly one more re-boot.
    repeat ($urandom_range(0, 4)) @(posedge clock);
    #1;
    fill_rom();
    push_boot();
    start_a = 1'b1;
    @(posedge clock); #1;
    wait_done_a(400);
    push_boot();
    @(posedge clock); #1;
    start_a = 1'b0;
    check("held_start_reboot_hold", 32'(hold_a), 32'd1);
    wait_done_a(400);

    // Reset mid-copy at cnt=50: immediate abort, then a full boot.
    push_boot();
    start_a = 1'b1;
    @(posedge clock); #1;
    start_a = 1'b0;
    i = 0;
    while (ba_a != AW'(50) && i < 200) begin
      @(posedge clock); #1;
      i++;
    end
    check("reach_cnt50", 32'(ba_a), 32'd50);
    #2 rst_a = 1'b0;
    #1;
    check("abort_wr_en", 32'(we_a), 32'd0);
    check("abort_hold", 32'(hold_a), 32'd1);
    check("abort_done", 32'(done_a), 32'd0);
    check("abort_bios_addr", 32'(ba_a), 32'd0);
    exp_q.delete();
    sum_q.delete();
    exp_boots--;
    repeat (2) @(posedge clock);
    #1;
    release_and_boot();
    wait_done_a(400);
    @(negedge clock); #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("sum_q_drained", 32'(sum_q.size()), 32'd0);
    check("boot_count", 32'(boots_a), 32'(exp_boots));

    // Single-word instance: one write per boot, checksum cleared on start.
    b_cnt = 0;
    rst_b = 1'b1;
    wait_done_b(20);
    check_b_boot();
    repeat ($urandom_range(0, 3)) @(posedge clock);
    #1;
    b_cnt = 0;
    start_b = 1'b1;
    @(posedge clock); #1;
    start_b = 1'b0;
    check("b_restart_hold", 32'(hold_b), 32'd1);
    check("b_restart_checksum_clr", sum_b, 32'd0);
    wait_done_b(20);
    check_b_boot();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop if something wedges despite the bounded waits.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
